// File: rtl/tape_arb_pkg.sv
// Shared types and default widths for the tape RAM arbiter.
// The types cover the FSM state and which port issued the last RAM access.
package tape_arb_pkg;

    localparam int ARB_ADDR_WIDTH   = 16;
    localparam int ARB_DATA_WIDTH   = 8;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_CORE = 1'b0,
        ARB_PORT_HOST = 1'b1
    } arb_port_t;

endpackage

// File: rtl/tape_arbiter.sv
// Shares the single-port tape RAM between the CPU core and the host/debug port.
// Core has priority, bounded by a streak counter so a waiting host always gets a slot.
module tape_arbiter
    import tape_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_hold,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output arb_state_t            state_dbg
);

    // Handshake: a requester holds req with addr/we/wdata stable until gnt pulses;
    // gnt marks the cycle the access reaches the RAM, and for reads rvalid pulses
    // exactly one cycle later with rdata valid. There is no back-pressure on rvalid.

    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t            state, state_nxt;
    arb_port_t             last_port;
    logic [STREAK_W-1:0]   streak, streak_nxt;
    logic                  core_elig;
    logic                  grant_core, grant_host;

    assign core_rdata = ram_rdata;
    assign host_rdata = ram_rdata;
    assign state_dbg  = state;

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        grant_core = 1'b0;
        grant_host = 1'b0;
        core_elig  = core_req & ~host_hold;
        case (state)
            ARB_IDLE: begin
                if (core_elig && host_req) begin
                    if (streak >= STREAK_MAX) grant_host = 1'b1;
                    else                      grant_core = 1'b1;
                end else if (core_elig) begin
                    grant_core = 1'b1;
                end else if (host_req) begin
                    grant_host = 1'b1;
                end
                // A core win only counts against the host while the host is waiting.
                if (grant_host || !host_req) streak_nxt = '0;
                else if (grant_core)         streak_nxt = streak + STREAK_W'(1);
                if (grant_core || grant_host) state_nxt = ARB_ISSUE;
            end
            ARB_ISSUE: state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            streak      <= '0;
            last_port   <= ARB_PORT_CORE;
            core_gnt    <= 1'b0;
            host_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            streak      <= streak_nxt;
            core_gnt    <= grant_core;
            host_gnt    <= grant_host;
            ram_en      <= grant_core | grant_host;
            ram_we      <= (grant_core & core_we) | (grant_host & host_we);
            // The RAM returns read data the cycle after the access strobe.
            core_rvalid <= ram_en & ~ram_we & (last_port == ARB_PORT_CORE);
            host_rvalid <= ram_en & ~ram_we & (last_port == ARB_PORT_HOST);
            if (grant_core) begin
                ram_addr  <= core_addr;
                ram_wdata <= core_wdata;
                last_port <= ARB_PORT_CORE;
            end else if (grant_host) begin
                ram_addr  <= host_addr;
                ram_wdata <= host_wdata;
                last_port <= ARB_PORT_HOST;
            end
        end
    end

endmodule

// File: tb/tb_tape_arbiter.sv
// Bench for tape_arbiter: a cycle-level model of the arbitration rules predicts every
// output each cycle, and directed scenarios pin the model with hand-computed values.
module tb_tape_arbiter;
    import tape_arb_pkg::*;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        cg, hg, en, we, crv, hrv;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        core_req, core_we, host_req, host_we, host_hold;
    logic [15:0] core_addr, host_addr;
    logic [7:0]  core_wdata, host_wdata;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [7:0]  core_rdata, host_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    arb_state_t  state_dbg;

    // second instance with strict host priority
    logic        c2_req, h2_req, z_bit;
    logic [15:0] z_addr;
    logic [7:0]  z_data;
    logic        c2_gnt, c2_rvalid, h2_gnt, h2_rvalid, ram2_en, ram2_we;
    logic [7:0]  c2_rdata, h2_rdata, ram2_wdata;
    logic [7:0]  ram2_rdata = 8'h00;
    logic [15:0] ram2_addr;
    arb_state_t  state2;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          crv_cnt = 0;
    int          hrv_cnt = 0;

    exp_t        exp_m [int];
    logic [7:0]  exp_q [$];
    logic [7:0]  mem_m [int];
    int          streak_m = 0;
    int          last_gnt = -100;

    bit [7:0]    ram_mem [256];
    bit          ram_wr  [256];

    tape_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_hold(host_hold), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .state_dbg(state_dbg)
    );

    tape_arbiter #(.STARVE_LIMIT(0)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .core_req(c2_req), .core_we(z_bit), .core_addr(z_addr), .core_wdata(z_data),
        .core_gnt(c2_gnt), .core_rvalid(c2_rvalid), .core_rdata(c2_rdata),
        .host_req(h2_req), .host_we(z_bit), .host_addr(z_addr), .host_wdata(z_data),
        .host_hold(z_bit), .host_gnt(h2_gnt), .host_rvalid(h2_rvalid), .host_rdata(h2_rdata),
        .ram_en(ram2_en), .ram_we(ram2_we), .ram_addr(ram2_addr), .ram_wdata(ram2_wdata),
        .ram_rdata(ram2_rdata), .state_dbg(state2)
    );

    // ---------------- clock / reset / RAM ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ 8'h4A;
    endfunction

    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr[7:0]] <= ram_wdata;
                ram_wr[ram_addr[7:0]]  <= 1'b1;
            end else begin
                ram_rdata <= ram_wr[ram_addr[7:0]] ? ram_mem[ram_addr[7:0]] : init_val(ram_addr);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no grant within bound, got none, expected one (cycle %0d)", name, cyc);
    endtask

    // Scoreboard + model: at each falling edge compare the DUT against the prediction
    // for this cycle, then apply the arbitration rules to the current requests.
    task automatic monitor();
        exp_t        e;
        bit          ce, he, win_c, win_h, wr;
        logic [15:0] a;
        logic [7:0]  d;
        forever begin
            @(negedge clock);
            e = '0;
            if (reset_n && exp_m.exists(cyc)) e = exp_m[cyc];
            check("ctl{cg,hg,en,we,crv,hrv}",
                  32'({core_gnt, host_gnt, ram_en, ram_we, core_rvalid, host_rvalid}),
                  32'({e.cg, e.hg, e.en, e.we, e.crv, e.hrv}));
            if (e.en)         check("ram_addr", 32'(ram_addr), 32'(e.addr));
            if (e.en && e.we) check("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
            if (core_rvalid) crv_cnt++;
            if (host_rvalid) hrv_cnt++;
            if (reset_n && (core_rvalid || host_rvalid)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rdata: got unexpected rvalid, expected none (cycle %0d)", cyc);
                end else begin
                    check("rdata", 32'(core_rvalid ? core_rdata : host_rdata), 32'(exp_q.pop_front()));
                end
            end
            if (exp_m.exists(cyc)) exp_m.delete(cyc);

            if (!reset_n) begin
                exp_m.delete();
                exp_q.delete();
                streak_m = 0;
                last_gnt = -100;
            end else if (cyc != last_gnt) begin
                ce    = core_req && !host_hold;
                he    = host_req;
                win_h = he && (!ce || streak_m >= LIMIT);
                win_c = ce && !win_h;
                if (!he || win_h) streak_m = 0;
                else if (win_c)   streak_m++;
                if (win_c || win_h) begin
                    wr = win_h ? host_we : core_we;
                    a  = win_h ? host_addr : core_addr;
                    d  = win_h ? host_wdata : core_wdata;
                    e = '0;
                    e.cg = win_c; e.hg = win_h; e.en = 1'b1; e.we = wr; e.addr = a; e.wdata = d;
                    exp_m[cyc + 1] = e;
                    last_gnt = cyc + 1;
                    if (wr) begin
                        mem_m[int'(a)] = d;
                    end else begin
                        e = '0;
                        e.crv = win_c; e.hrv = win_h;
                        exp_m[cyc + 2] = e;
                        exp_q.push_back(mem_m.exists(int'(a)) ? mem_m[int'(a)] : init_val(a));
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_gnt(input bit host, input string name, output int g);
        g = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (host ? host_gnt : core_gnt) begin
                g = cyc;
                break;
            end
        end
        if (g < 0) timeout(name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int         r, g, g1, g2, base_c, base_h, ng, nh, nc, nrv, nen, run, max_run;
        logic [9:0] order;

        reset_n = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_hold = 0;
        c2_req = 0; h2_req = 0; z_bit = 0; z_addr = '0; z_data = '0;
        fork monitor(); join_none

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ctl", 32'({core_gnt, host_gnt, ram_en, ram_we, core_rvalid, host_rvalid}), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(ARB_IDLE));
        @(posedge clock); #1 reset_n = 1'b1;
        idle(2);

        // core read of RAM[0x10] = 0x5A with the host idle
        core_req = 1; core_we = 0; core_addr = 16'h0010; r = cyc;
        wait_gnt(0, "t1_gnt", g);
        check("t1_gnt_latency", 32'(g - r), 32'd1);
        check("t1_ram_addr", 32'(ram_addr), 32'h0010);
        check("t1_ram_en_we", 32'({ram_en, ram_we}), 32'b10);
        @(posedge clock); #1 core_req = 0;
        @(negedge clock);
        check("t1_rvalid", 32'(core_rvalid), 32'd1);
        check("t1_rdata", 32'(core_rdata), 32'h5A);
        idle(2);

        // host write 0x0003 <= 0x7F, then read it back with req held high
        base_c = crv_cnt; base_h = hrv_cnt;
        host_req = 1; host_we = 1; host_addr = 16'h0003; host_wdata = 8'h7F;
        wait_gnt(1, "t2_write_gnt", g1);
        @(posedge clock); #1 host_we = 0;
        wait_gnt(1, "t2_read_gnt", g2);
        @(posedge clock); #1 host_req = 0;
        @(negedge clock);
        check("t2_rvalid", 32'(host_rvalid), 32'd1);
        check("t2_rdata", 32'(host_rdata), 32'h7F);
        repeat (3) @(negedge clock);
        check("t2_gnt_gap", 32'(g2 - g1), 32'd2);
        check("t2_core_rvalids", 32'(crv_cnt - base_c), 32'd0);
        check("t2_host_rvalids", 32'(hrv_cnt - base_h), 32'd1);
        idle(1);

        // both requesting continuously: C,C,C,C,H repeating
        core_req = 1; core_we = 0; core_addr = 16'h0020;
        host_req = 1; host_we = 0; host_addr = 16'h0030;
        order = '0; ng = 0; nh = 0; run = 0; max_run = 0;
        for (int n = 0; n < 60 && ng < 20; n++) begin
            @(negedge clock);
            if (core_gnt || host_gnt) begin
                if (ng < 10) order = {order[8:0], host_gnt};
                ng++;
                if (host_gnt) begin
                    nh++;
                    run = 0;
                end else begin
                    run++;
                    if (run > max_run) max_run = run;
                end
            end
        end
        @(posedge clock); #1 core_req = 0; host_req = 0;
        check("t3_order", 32'(order), 32'b0000100001);
        check("t3_grants", 32'(ng), 32'd20);
        check("t3_host_grants", 32'(nh), 32'd4);
        check("t3_max_core_run", 32'(max_run), 32'd4);
        idle(3);

        // host_hold freezes the core; release grants one cycle later
        host_hold = 1; core_req = 1; core_we = 1; core_addr = 16'h0040; core_wdata = 8'hA5;
        nc = 0;
        repeat (10) begin
            @(negedge clock);
            if (core_gnt) nc++;
        end
        check("t4_held_gnts", 32'(nc), 32'd0);
        @(posedge clock); #1 host_hold = 0; r = cyc;
        wait_gnt(0, "t4_gnt", g);
        check("t4_release_latency", 32'(g - r), 32'd1);
        @(posedge clock); #1 core_req = 0;
        idle(3);

        // reset during ISSUE of a core read
        base_c = crv_cnt;
        core_req = 1; core_we = 0; core_addr = 16'h0010;
        wait_gnt(0, "t5_gnt", g);
        #1 reset_n = 1'b0; core_req = 0;
        #1;
        check("t5_async_ctl", 32'({core_gnt, host_gnt, ram_en, ram_we, core_rvalid, host_rvalid}), 32'd0);
        check("t5_async_ram_addr", 32'(ram_addr), 32'd0);
        check("t5_async_ram_wdata", 32'(ram_wdata), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("t5_no_rvalid", 32'(crv_cnt - base_c), 32'd0);
        check("t5_state", 32'(state_dbg), 32'(ARB_IDLE));
        idle(1);

        // STARVE_LIMIT = 0: host strict priority
        c2_req = 1; h2_req = 1;
        nc = 0; nh = 0; nrv = 0; nen = 0;
        repeat (12) begin
            @(negedge clock);
            nc += 32'(c2_gnt); nh += 32'(h2_gnt);
            nrv += 32'(c2_rvalid) + 32'(h2_rvalid); nen += 32'(ram2_en);
        end
        check("t6_host_grants", 32'(nh), 32'd6);
        check("t6_core_grants", 32'(nc), 32'd0);
        check("t6_rvalids", 32'(nrv), 32'd5);
        check("t6_ram_en", 32'(nen), 32'd6);
        @(posedge clock); #1 h2_req = 0;
        nc = 0; nh = 0; nrv = 0;
        repeat (8) begin
            @(negedge clock);
            nc += 32'(c2_gnt); nh += 32'(h2_gnt);
            nrv += 32'(c2_rvalid) + 32'(h2_rvalid);
        end
        check("t6_core_after", 32'(nc), 32'd4);
        check("t6_host_after", 32'(nh), 32'd0);
        check("t6_rvalids_after", 32'(nrv), 32'd4);
        @(posedge clock); #1 c2_req = 0;

        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
